poly_area: RTL and testbench

POLY_AREA -- requirements
Module: poly_area

---
 rtl/poly_area.sv | 152 +++++++++++++++
 tb/tb_poly_area.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_area.sv
// poly_area -- streaming shoelace accumulator for one polygon of N_PTS vertices.
//
// Vertices arrive one per accepted cycle in polygon order. The block sums
// x_i*y_(i+1) - x_(i+1)*y_i over the set, closes the ring with the
// last->first term, then reports the magnitude and orientation of the sum.
//
// Handshake: a vertex is taken on a rising edge when in_valid && in_ready.
// in_ready depends only on the registered state (high in IDLE and ACC); a
// vertex offered while in_ready is low is dropped, never stalled. out_valid
// is a single-cycle pulse and area/ccw hold their value until the next pulse.
//
// Configuration macro: POLY_AREA_HALF_EN
//   defined   : area = |S| >> 1 (true polygon area, floored)
//   undefined : area = |S|      (doubled area, exact)
//
// Parameters:
//   N_PTS        vertices per polygon, 3..15
// Ports:
//   clk          clock, rising edge
//   reset        synchronous, active-high
//   in_valid     qualifies inX/inY
//   inX, inY     unsigned 8-bit vertex coordinates
//   in_ready     vertex accepted this cycle when in_valid is high
//   area         20-bit unsigned magnitude result
//   ccw          1 when the signed sum is strictly positive
//   out_valid    one-cycle pulse qualifying area/ccw
//   o_dbg_state  current FSM state (IDLE=0, ACC=1, CLOSE=2, DONE=3)
module poly_area #(
  parameter int N_PTS = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  inX,
  input  logic [7:0]  inY,
  output logic        in_ready,
  output logic [19:0] area,
  output logic        ccw,
  output logic        out_valid,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    CLOSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic [3:0]         r_count;
  logic signed [20:0] r_acc;
  logic [7:0]         r_first_x;
  logic [7:0]         r_first_y;
  logic [7:0]         r_prev_x;
  logic [7:0]         r_prev_y;
  logic [19:0]        r_area;
  logic               r_ccw;
  logic               r_out_valid;

  // One shared term datapath: the "next" vertex is the incoming one while
  // accumulating and the stored first vertex when closing the ring.
  logic [7:0]         w_next_x;
  logic [7:0]         w_next_y;
  logic [15:0]        w_p1;
  logic [15:0]        w_p2;
  logic signed [20:0] w_term;
  logic [19:0]        w_abs;
  logic [19:0]        w_area;
  logic               w_ccw;

  always_comb begin
    w_next_x = (r_state == CLOSE) ? r_first_x : inX;
    w_next_y = (r_state == CLOSE) ? r_first_y : inY;
    w_p1     = 16'(r_prev_x) * 16'(w_next_y);
    w_p2     = 16'(w_next_x) * 16'(r_prev_y);
    // Products are unsigned; zero-extend before the signed subtraction.
    w_term   = $signed({5'd0, w_p1}) - $signed({5'd0, w_p2});
  end

  // |S| never exceeds 2^20 - 1 for N_PTS <= 15, so 20 bits hold it.
  always_comb begin
    w_abs = r_acc[20] ? 20'(-r_acc) : r_acc[19:0];
    w_ccw = ~r_acc[20] && (r_acc != 21'sd0);
`ifdef POLY_AREA_HALF_EN
    w_area = w_abs >> 1;
`else
    w_area = w_abs;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_count     <= 4'd0;
      r_acc       <= 21'sd0;
      r_first_x   <= 8'd0;
      r_first_y   <= 8'd0;
      r_prev_x    <= 8'd0;
      r_prev_y    <= 8'd0;
      r_area      <= 20'd0;
      r_ccw       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_first_x <= inX;
            r_first_y <= inY;
            r_prev_x  <= inX;
            r_prev_y  <= inY;
            r_count   <= 4'd1;
            r_acc     <= 21'sd0;
            r_state   <= ACC;
          end
        end
        ACC: begin
          if (in_valid) begin
            r_acc    <= r_acc + w_term;
            r_prev_x <= inX;
            r_prev_y <= inY;
            r_count  <= r_count + 4'd1;
            // r_count still holds the pre-increment value here.
            if (r_count == 4'(N_PTS - 1)) begin
              r_state <= CLOSE;
            end
          end
        end
        CLOSE: begin
          r_acc   <= r_acc + w_term;
          r_state <= DONE;
        end
        DONE: begin
          r_area      <= w_area;
          r_ccw       <= w_ccw;
          r_out_valid <= 1'b1;
          r_count     <= 4'd0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE) || (r_state == ACC);
  assign area        = r_area;
  assign ccw         = r_ccw;
  assign out_valid   = r_out_valid;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_poly_area.sv
// Testbench for poly_area with N_PTS = 6.
// Expected {area, ccw} values go into exp_q when a polygon is driven; a
// negedge monitor pops and compares on every out_valid pulse.
module tb_poly_area;

  localparam int N = 6;

`ifdef POLY_AREA_HALF_EN
  localparam logic [19:0] A_RECT = 20'd200;
  localparam logic [19:0] A_FULL = 20'd65025;
`else
  localparam logic [19:0] A_RECT = 20'd400;
  localparam logic [19:0] A_FULL = 20'd130050;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  inX;
  logic [7:0]  inY;
  logic        in_ready;
  logic [19:0] area;
  logic        ccw;
  logic        out_valid;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int pushes = 0;

  logic [20:0] exp_q[$];
  logic [20:0] mon_exp;
  int vx[N];
  int vy[N];

  poly_area #(.N_PTS(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .inX        (inX),
    .inY        (inY),
    .in_ready   (in_ready),
    .area       (area),
    .ccw        (ccw),
    .out_valid  (out_valid),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got area=%0d ccw=%0d, expected no output", area, ccw);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({area, ccw} !== mon_exp) begin
          errors++;
          $display("FAIL result: got area=%0d ccw=%0d, expected area=%0d ccw=%0d",
                   area, ccw, mon_exp[20:1], mon_exp[0]);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [20:0] model(input int xs[N], input int ys[N]);
    int s;
    int mag;
    s = 0;
    for (int i = 0; i < N; i++) begin
      s += xs[i] * ys[(i + 1) % N] - xs[(i + 1) % N] * ys[i];
    end
    mag = (s < 0) ? -s : s;
`ifdef POLY_AREA_HALF_EN
    mag = mag / 2;
`endif
    return {20'(mag), (s > 0)};
  endfunction

  // ---------------- drivers (called at posedge + 1) ----------------
  task automatic drive_vtx(input int x, input int y);
    in_valid = 1'b1;
    inX = 8'(x);
    inY = 8'(y);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_accept: got %b, expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_set(input int gap, input logic [20:0] exp);
    exp_q.push_back(exp);
    pushes++;
    for (int i = 0; i < N; i++) begin
      if (i > 0) repeat (gap) begin @(posedge clk); #1; end
      drive_vtx(vx[i], vy[i]);
    end
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout: %0d results still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_rect();
    vx = '{0, 10, 20, 20, 10, 0};
    vy = '{0, 0, 0, 10, 10, 10};
  endtask

  task automatic load_rect_rev();
    vx = '{0, 10, 20, 20, 10, 0};
    vy = '{10, 10, 10, 0, 0, 0};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b1;  // reset must win over a valid vertex
    inX = 8'd99;
    inY = 8'd42;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({in_ready, out_valid, ccw} !== 3'b100 || area !== 20'd0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b ov=%b ccw=%b area=%0d st=%0d, expected 1 0 0 0 0",
               in_ready, out_valid, ccw, area, dbg_state);
    end
  endtask

  task automatic test_rect_latency();
    load_rect();
    send_set(0, {A_RECT, 1'b1});
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || dbg_state !== 2'd2) begin
      errors++;
      $display("FAIL lat_k1: got ov=%b rdy=%b st=%0d, expected 0 0 2", out_valid, in_ready, dbg_state);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || dbg_state !== 2'd3) begin
      errors++;
      $display("FAIL lat_k2: got ov=%b rdy=%b st=%0d, expected 0 0 3", out_valid, in_ready, dbg_state);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL lat_pulse: got ov=%b rdy=%b, expected 1 1", out_valid, in_ready);
    end
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (area !== A_RECT || ccw !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold: got area=%0d ccw=%b ov=%b, expected %0d 1 0", area, ccw, out_valid, A_RECT);
    end
  endtask

  task automatic test_reverse();
    load_rect_rev();
    send_set(0, {A_RECT, 1'b0});
    wait_idle();
  endtask

  task automatic test_full_range();
    vx = '{0, 255, 255, 255, 0, 0};
    vy = '{0, 0, 255, 255, 255, 255};
    send_set(0, {A_FULL, 1'b1});
    wait_idle();
  endtask

  task automatic test_degenerate();
    vx = '{37, 37, 37, 37, 37, 37};
    vy = '{91, 91, 91, 91, 91, 91};
    send_set(1, {20'd0, 1'b0});
    wait_idle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_gaps_and_drop();
    load_rect();
    send_set(3, {A_RECT, 1'b1});
    // Offer junk vertices while the block is closing and reporting.
    in_valid = 1'b1;
    inX = 8'd200;
    inY = 8'd7;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL busy_ready_%0d: got %b, expected 0", c, in_ready);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL drop_state: got %0d, expected 0", dbg_state);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    load_rect();
    for (int i = 0; i < 3; i++) drive_vtx(vx[i], vy[i]);
    reset = 1'b1;
    in_valid = 1'b1;
    inX = 8'd5;
    inY = 8'd5;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (area !== 20'd0 || ccw !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset: got area=%0d ccw=%b st=%0d, expected 0 0 0", area, ccw, dbg_state);
    end
    load_rect_rev();
    send_set(0, {A_RECT, 1'b0});
    wait_idle();
  endtask

  task automatic test_back_to_back();
    load_rect();
    send_set(0, {A_RECT, 1'b1});
    repeat (2) begin @(posedge clk); #1; end
    // Now in the out_valid cycle; start the next set immediately.
    vx = '{0, 255, 255, 255, 0, 0};
    vy = '{0, 0, 255, 255, 255, 255};
    send_set(0, {A_FULL, 1'b1});
    wait_idle();
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N; i++) begin
        vx[i] = int'($urandom_range(0, 255));
        vy[i] = int'($urandom_range(0, 255));
      end
      send_set(int'($urandom_range(0, 2)), model(vx, vy));
      wait_idle();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    inX = 8'd0;
    inY = 8'd0;
    @(posedge clk);
    #1;
    test_reset();
    test_rect_latency();
    test_reverse();
    test_full_range();
    test_degenerate();
    test_gaps_and_drop();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (pulses !== pushes) begin
      errors++;
      $display("FAIL pulse_count: got %0d, expected %0d", pulses, pushes);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
